instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage of the 8-bit nRISC core. Holds the PC and reads one 8-bit instruction
//  per step from instruction memory over a req/ack handshake. Latches it into the IR
//  and presents opcode IR[7:5] to the control unit. Computes the next PC (sequential,
//  jmp, taken beq) once the execute side reports completion.
// PARAMETERS
//  PC_WIDTH   8  PC / instruction-memory address width
//  RESET_PC   0  PC value loaded on reset
//  CNT_WIDTH  16 width of retired-instruction counter
// PORTS
//  clk         in   1         rising-edge clock
//  reset       in   1         synchronous, active-high
//  imem_req    out  1         fetch request to instruction memory
//  imem_addr   out  PC_WIDTH  fetch address (= pc)
//  imem_ack    in   1         memory returns imem_rdata this cycle
//  imem_rdata  in   8         instruction word
//  instr       out  8         instruction register (IR)
//  opcode      out  3         IR[7:5], to control unit
//  instr_valid out  1         IR holds a decoded-ready instruction
//  exec_done   in   1         execute/writeback finished current instruction
//  zero        in   1         ULA zero flag for beq, sampled with exec_done
//  pc          out  PC_WIDTH  current PC
//  retired     out  CNT_WIDTH count of completed instructions
// BEHAVIOUR
//  - Reset: state=FETCH, pc=RESET_PC, IR=0, retired=0.
//    imem_req=0 and instr_valid=0 in the reset cycle.
//    Reset mid-fetch or mid-exec aborts the instruction. No PC or counter update.
//  - All outputs registered or decoded from state only. No comb path from inputs to outputs.
//  - FSM FETCH:
//    - imem_req=1, imem_addr=pc. Held stable until ack.
//    - On sampled imem_ack=1: IR<=imem_rdata, go to EXEC. imem_req drops next cycle.
//  - FSM EXEC:
//    - instr_valid=1, IR/opcode stable.
//    - On sampled exec_done=1: pc<=next_pc, retired<=retired+1, go to FETCH.
//  - next_pc (mod 2^PC_WIDTH, wraps silently):
//    - opcode 101 (jmp): zero-extended IR[4:0].
//    - opcode 110 (beq) and zero=1: pc+1+sign-extended IR[4:0].
//    - all others, incl. beq with zero=0: pc+1.
//  - imem_ack outside FETCH: ignored. exec_done outside EXEC: ignored.
//  - Ack and exec_done can never both take effect in one cycle: exclusive states.
//  - Min throughput: 2 cycles/instr (ack in first FETCH cycle, exec_done in first EXEC cycle).
//  - retired wraps to 0 after all-ones.
//  - pc=2^PC_WIDTH-1 sequential: next pc=0.
//  - beq offset -1 targets pc itself (legal self-loop).
// TESTING
//  1. Reset, ack=1 each FETCH, IMEM[0..2]=8'h40,8'h60,8'h41, exec_done=1 each EXEC
//     -> imem_addr 0,1,2.
//     -> opcode 010,011,010.
//     -> retired=3 after 6 cycles.
//  2. IMEM[4]=8'hB5 (jmp 21), exec_done -> next imem_addr=8'd21.
//  3. pc=10, IR=8'hDE (beq -2), zero=1 -> pc=9.
//     Same instruction with zero=0 -> pc=11.
//  4. imem_ack held low 5 cycles -> imem_req=1, imem_addr constant, instr_valid=0 throughout.
//     Ack on cycle 6 -> instr_valid=1 next cycle.
//  5. pc=8'hFF, non-branch, exec_done -> pc=8'h00.
//     retired preset all-ones, exec_done -> retired=0.
//  6. Reset asserted during EXEC with exec_done=1 -> pc=RESET_PC, retired unchanged from 0.
//     Next cycle: state FETCH, imem_req=1.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//    Fetch stage of the 8-bit nRISC core. Holds the PC, fetches one 8-bit
//    instruction per step from instruction memory over a req/ack handshake,
//    latches it into the IR and exposes the opcode (IR[7:5]) to the control
//    unit. Once the execute side reports completion, the PC advances to the
//    sequential, jump or taken-branch target and the retired counter ticks.
//
// Ports
//    clk          in   rising-edge clock
//    reset        in   synchronous, active-high reset
//    imem_req     out  fetch request to instruction memory
//    imem_addr    out  fetch address (always equal to pc)
//    imem_ack     in   instruction memory returns imem_rdata this cycle
//    imem_rdata   in   instruction word
//    instr        out  instruction register (IR)
//    opcode       out  IR[7:5], to the control unit
//    instr_valid  out  IR holds an instruction ready for decode
//    exec_done    in   execute/writeback finished the current instruction
//    zero         in   ALU zero flag for beq, sampled together with exec_done
//    pc           out  current program counter
//    retired      out  count of completed instructions (wraps)
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter int                  PC_WIDTH  = 8,
   parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
   parameter int                  CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   output logic                 imem_req,
   output logic [PC_WIDTH-1:0]  imem_addr,
   input  logic                 imem_ack,
   input  logic [7:0]           imem_rdata,
   output logic [7:0]           instr,
   output logic [2:0]           opcode,
   output logic                 instr_valid,
   input  logic                 exec_done,
   input  logic                 zero,
   output logic [PC_WIDTH-1:0]  pc,
   output logic [CNT_WIDTH-1:0] retired
);

   localparam logic [2:0] OP_JMP = 3'b101;
   localparam logic [2:0] OP_BEQ = 3'b110;

   typedef enum logic {
      FETCH = 1'b0,
      EXEC  = 1'b1
   } state_t;

   state_t              state;
   logic [PC_WIDTH-1:0] seq_pc;
   logic [PC_WIDTH-1:0] jmp_target;
   logic [PC_WIDTH-1:0] branch_offset;
   logic [PC_WIDTH-1:0] next_pc;

   // Outputs come straight from registers, so there is no combinational
   // path from any input to any output.
   assign imem_addr = pc;
   assign opcode    = instr[7:5];

   // Target selection. All arithmetic is modulo 2^PC_WIDTH, so the PC wraps
   // silently past the top of memory and a beq offset of -1 loops on itself.
   always_comb begin
      seq_pc        = pc + PC_WIDTH'(1);
      jmp_target    = {{(PC_WIDTH-5){1'b0}}, instr[4:0]};
      branch_offset = {{(PC_WIDTH-5){instr[4]}}, instr[4:0]};
      next_pc       = seq_pc;
      if (opcode == OP_JMP) begin
         next_pc = jmp_target;
      end else if ((opcode == OP_BEQ) && zero) begin
         next_pc = seq_pc + branch_offset;
      end
   end

   // imem_req and instr_valid are registered alongside the state. The cycle
   // right after reset is a bubble with imem_req low; an ack is only accepted
   // while imem_req is actually asserted, so a stray ack in that bubble (or
   // during EXEC) has no effect.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= FETCH;
         imem_req    <= 1'b0;
         instr_valid <= 1'b0;
         pc          <= RESET_PC;
         instr       <= '0;
         retired     <= '0;
      end else begin
         case (state)
            FETCH: begin
               imem_req <= 1'b1;
               if (imem_req && imem_ack) begin
                  instr       <= imem_rdata;
                  state       <= EXEC;
                  imem_req    <= 1'b0;
                  instr_valid <= 1'b1;
               end
            end
            EXEC: begin
               if (exec_done) begin
                  pc          <= next_pc;
                  retired     <= retired + CNT_WIDTH'(1);
                  state       <= FETCH;
                  imem_req    <= 1'b1;
                  instr_valid <= 1'b0;
               end
            end
            default: begin
               state <= FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit
//    Self-checking bench for instr_fetch_unit. A small behavioural model
//    (phase, pc, IR, retired count) is advanced from the same inputs the DUT
//    sees and every output is compared on every falling edge. Directed
//    sequences pin the model with literal expectations, then a randomized
//    phase exercises stalls, stray acks/exec_done and random resets.
//    The retired counter is instantiated 8 bits wide so its wrap is reachable.
// ----------------------------------------------------------------------------
module tb_instr_fetch_unit;

   localparam int CW = 8;

   localparam int M_BUBBLE = 0;
   localparam int M_REQ    = 1;
   localparam int M_EXEC   = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          imem_req;
   logic [7:0]    imem_addr;
   logic          imem_ack;
   logic [7:0]    imem_rdata;
   logic [7:0]    instr;
   logic [2:0]    opcode;
   logic          instr_valid;
   logic          exec_done;
   logic          zero;
   logic [7:0]    pc;
   logic [CW-1:0] retired;

   always #5 clk = ~clk;

   instr_fetch_unit #(
      .PC_WIDTH (8),
      .RESET_PC (8'd0),
      .CNT_WIDTH(CW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .instr      (instr),
      .opcode     (opcode),
      .instr_valid(instr_valid),
      .exec_done  (exec_done),
      .zero       (zero),
      .pc         (pc),
      .retired    (retired)
   );

   int tests = 0;
   int fails = 0;

   logic [7:0]    mem [256];

   // behavioural model
   int            m_phase;
   logic [7:0]    m_pc;
   logic [7:0]    m_ir;
   logic [CW-1:0] m_retired;

   function automatic logic [7:0] model_next_pc(input logic [7:0] ir, input logic [7:0] p,
                                                input logic z);
      int off;
      off = int'(ir[4:0]);
      if (off > 15) off = off - 32;
      if (ir[7:5] == 3'b101) return 8'(int'(ir[4:0]));
      if (ir[7:5] == 3'b110 && z) return 8'(int'(p) + 1 + off);
      return 8'(int'(p) + 1);
   endfunction

   function automatic void model_step(input logic r, input logic a, input logic [7:0] rd,
                                      input logic d, input logic z);
      logic [7:0] np;
      if (r) begin
         m_phase   = M_BUBBLE;
         m_pc      = 8'd0;
         m_ir      = 8'd0;
         m_retired = '0;
      end else if (m_phase == M_BUBBLE) begin
         m_phase = M_REQ;
      end else if (m_phase == M_REQ) begin
         if (a) begin
            m_ir    = rd;
            m_phase = M_EXEC;
         end
      end else if (d) begin
         np = model_next_pc(m_ir, m_pc, z);
         $display("[TB] retire pc=%02h ir=%02h zero=%0d next_pc=%02h", m_pc, m_ir, z, np);
         m_pc      = np;
         m_retired = m_retired + 1'b1;
         m_phase   = M_REQ;
      end
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic check_all();
      chk("imem_req",    32'(imem_req),    32'(m_phase == M_REQ));
      chk("instr_valid", 32'(instr_valid), 32'(m_phase == M_EXEC));
      chk("imem_addr",   32'(imem_addr),   32'(m_pc));
      chk("pc",          32'(pc),          32'(m_pc));
      chk("instr",       32'(instr),       32'(m_ir));
      chk("opcode",      32'(opcode),      32'(m_ir[7:5]));
      chk("retired",     32'(retired),     32'(m_retired));
   endtask

   // one clock: drive inputs (we are at a falling edge), advance model on
   // the rising edge, compare at the next falling edge
   task automatic cyc(input logic r, input logic a, input logic d, input logic z);
      reset      = r;
      imem_ack   = a;
      exec_done  = d;
      zero       = z;
      imem_rdata = (^imem_addr === 1'bx) ? 8'h00 : mem[imem_addr];
      @(posedge clk);
      model_step(r, a, imem_rdata, d, z);
      @(negedge clk);
      check_all();
   endtask

   // complete one instruction as fast as possible from wherever the model is
   task automatic run_instr(input logic z);
      int g;
      g = 0;
      while (m_phase != M_REQ && g < 4) begin
         cyc(1'b0, 1'b0, logic'(m_phase == M_EXEC), 1'b0);
         g++;
      end
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, z);
   endtask

   logic [2:0] exp_ops [3];

   initial begin
      exp_ops[0] = 3'b010;
      exp_ops[1] = 3'b011;
      exp_ops[2] = 3'b010;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[0]  = 8'h40;
      mem[1]  = 8'h60;
      mem[2]  = 8'h41;
      mem[3]  = 8'h20;
      mem[4]  = 8'hB5;  // jmp 21
      mem[21] = 8'hAA;  // jmp 10
      mem[10] = 8'hDE;  // beq -2
      mem[9]  = 8'hAA;  // jmp 10
      mem[11] = 8'h00;
      mem[12] = 8'hD2;  // beq -14 -> 0xFF
      mem[255] = 8'h3C;
      m_phase = M_BUBBLE; m_pc = 8'd0; m_ir = 8'd0; m_retired = '0;
      reset = 1'b1; imem_ack = 1'b0; exec_done = 1'b0; zero = 1'b0; imem_rdata = 8'h00;

      // reset, with stray ack/exec_done that must be ignored
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      chk("reset imem_req",    32'(imem_req),    32'd0);
      chk("reset instr_valid", 32'(instr_valid), 32'd0);
      chk("reset pc",          32'(pc),          32'd0);
      chk("reset retired",     32'(retired),     32'd0);
      chk("reset instr",       32'(instr),       32'd0);

      // bubble after reset: ack here is not accepted
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      chk("post-reset imem_req",    32'(imem_req),    32'd1);
      chk("post-reset instr_valid", 32'(instr_valid), 32'd0);

      // back-to-back fetch/exec of three instructions
      for (int i = 0; i < 3; i++) begin
         chk("seq imem_addr", 32'(imem_addr), 32'(i));
         cyc(1'b0, 1'b1, 1'b0, 1'b0);
         chk("seq opcode", 32'(opcode), 32'(exp_ops[i]));
         chk("seq instr_valid", 32'(instr_valid), 32'd1);
         cyc(1'b0, 1'b0, 1'b1, 1'b0);
      end
      chk("retired after 3", 32'(retired), 32'd3);
      run_instr(1'b0);
      chk("pc before jmp", 32'(pc), 32'd4);

      // jmp 21
      run_instr(1'b0);
      chk("jmp imem_addr", 32'(imem_addr), 32'd21);
      run_instr(1'b0);
      chk("jmp pc 10", 32'(pc), 32'd10);

      // beq -2 taken and not taken
      run_instr(1'b1);
      chk("beq taken pc", 32'(pc), 32'd9);
      run_instr(1'b0);
      run_instr(1'b0);
      chk("beq not taken pc", 32'(pc), 32'd11);

      // memory stall: ack withheld five cycles
      for (int k = 0; k < 5; k++) begin
         cyc(1'b0, 1'b0, 1'b1, 1'b0);
         chk("stall imem_req",    32'(imem_req),    32'd1);
         chk("stall imem_addr",   32'(imem_addr),   32'd11);
         chk("stall instr_valid", 32'(instr_valid), 32'd0);
      end
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      chk("stall release valid", 32'(instr_valid), 32'd1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk("stall pc", 32'(pc), 32'd12);

      // backward branch to top of memory, then sequential wrap
      run_instr(1'b1);
      chk("beq to 0xFF", 32'(pc), 32'hFF);
      run_instr(1'b0);
      chk("pc wrap", 32'(pc), 32'h00);
      mem[0] = 8'hDF;  // beq -1: self loop
      run_instr(1'b1);
      chk("beq self loop", 32'(pc), 32'h00);

      // randomized traffic with stray handshakes and occasional resets
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(255));
      for (int i = 0; i < 3000; i++) begin
         cyc(logic'($urandom_range(63) == 0), logic'($urandom_range(1)),
             logic'($urandom_range(1)), logic'($urandom_range(1)));
      end

      // retired counter wrap
      begin
         int g;
         g = 0;
         while (m_retired != '1 && g < 300) begin
            run_instr(1'b0);
            g++;
         end
      end
      chk("retired all-ones", 32'(retired), 32'hFF);
      run_instr(1'b0);
      chk("retired wrap", 32'(retired), 32'd0);

      // reset during EXEC with exec_done high aborts the instruction
      mem[m_pc] = 8'hA7;  // jmp 7
      run_instr(1'b0);
      chk("pre-abort pc", 32'(pc), 32'd7);
      chk("pre-abort retired", 32'(retired), 32'd1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      chk("abort in exec", 32'(instr_valid), 32'd1);
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      chk("abort pc",      32'(pc),       32'd0);
      chk("abort retired", 32'(retired),  32'd0);
      chk("abort imem_req", 32'(imem_req), 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("abort then fetch", 32'(imem_req), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
